// File: rtl/noc_params.sv
// Shared NoC types for the virtual-channel buffer controller: flit layout,
// flit labels, VC id width and the controller FSM state encoding.
package noc_params;

  localparam int VC_SIZE   = 2;
  localparam int DATA_SIZE = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    flit_label_t            label;
    logic [VC_SIZE-1:0]     vc_id;
    logic [DATA_SIZE-1:0]   data;
  } flit_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VA     = 2'd1,
    ACTIVE = 2'd2
  } vc_state_t;

  // A packet opens on HEAD or HEADTAIL.
  function automatic logic is_head(input flit_label_t label);
    return (label == HEAD) || (label == HEADTAIL);
  endfunction

  // A packet closes on TAIL or HEADTAIL.
  function automatic logic is_tail(input flit_label_t label);
    return (label == TAIL) || (label == HEADTAIL);
  endfunction

endpackage

// File: rtl/vc_buffer_ctrl_if.sv
// Link-side bundle of the VC buffer controller. The slave modport is the
// controller, the master modport is whoever drives the upstream link and
// the allocators.
//
// Handshake semantics: every *_i strobe (valid_i, vc_valid_i, sa_grant_i,
// credit_i) is a single-cycle event taken at the rising clock edge where it
// is high; there is no ready back-pressure. Flow control is carried by
// credits (credit_o upstream, credit_i from downstream) and by is_full_o;
// a write while full with no simultaneous pop is dropped and flagged on
// error_o. Output strobes (flit_valid_o, credit_o, error_o) are one-cycle
// pulses, and flit_o is only meaningful while flit_valid_o is high.
interface vc_buffer_ctrl_if;
  import noc_params::*;

  flit_t              data_i;
  logic               valid_i;
  logic               vc_valid_i;
  logic [VC_SIZE-1:0] vc_new_i;
  logic               sa_grant_i;
  logic               credit_i;
  logic               va_request_o;
  logic               sa_request_o;
  flit_t              flit_o;
  logic               flit_valid_o;
  logic               credit_o;
  logic               error_o;
  logic               is_full_o;
  logic               is_empty_o;

  modport slave (
    input  data_i, valid_i, vc_valid_i, vc_new_i, sa_grant_i, credit_i,
    output va_request_o, sa_request_o, flit_o, flit_valid_o, credit_o,
           error_o, is_full_o, is_empty_o
  );

  modport master (
    output data_i, valid_i, vc_valid_i, vc_new_i, sa_grant_i, credit_i,
    input  va_request_o, sa_request_o, flit_o, flit_valid_o, credit_o,
           error_o, is_full_o, is_empty_o
  );

endinterface

// File: rtl/circular_buffer.sv
// First-word-fall-through flit FIFO. The front entry is visible on data_o
// without a read strobe; read_i pops it. A write while full is accepted only
// when a pop happens in the same cycle, otherwise it is dropped and
// overflow_o flags it combinationally.
module circular_buffer
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  flit_t data_i,
  input  logic  write_i,
  input  logic  read_i,
  output flit_t data_o,
  output logic  is_full_o,
  output logic  is_empty_o,
  output logic  overflow_o
);

  localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int CNT_W = $clog2(BUFFER_SIZE) + 1;

  flit_t            mem [BUFFER_SIZE];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_read;
  logic             do_write;

  // Explicit wrap so depths that are not a power of two still work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_SIZE - 1)) ? '0 : p + 1'b1;
  endfunction

  assign is_empty_o = (count == '0);
  assign is_full_o  = (count == CNT_W'(BUFFER_SIZE));
  assign do_read    = read_i && !is_empty_o;
  assign do_write   = write_i && (!is_full_o || do_read);
  assign overflow_o = write_i && is_full_o && !do_read;
  assign data_o     = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset empties the buffer logically.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= next_ptr(wr_ptr);
      if (do_read)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_write, do_read})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/vc_buffer_ctrl.sv
// Input virtual-channel controller: buffers incoming flits, requests a
// downstream VC for each packet, then requests the switch flit by flit while
// downstream credits remain. Granted flits leave one cycle later with their
// vc_id rewritten to the allocated VC, and a credit goes back upstream.
module vc_buffer_ctrl
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  vc_buffer_ctrl_if.slave              bus,
  output vc_state_t                    state_o,
  output logic [$clog2(BUFFER_SIZE):0] credits_o
);

  localparam int CNT_W = $clog2(BUFFER_SIZE) + 1;

  vc_state_t          state;
  vc_state_t          state_next;
  logic [CNT_W-1:0]   credits;
  logic [VC_SIZE-1:0] vc_q;
  flit_t              front;
  flit_t              fwd;
  flit_t              flit_q;
  logic               flit_valid_q;
  logic               credit_q;
  logic               error_q;
  logic               buf_pop;
  logic               buf_full;
  logic               buf_empty;
  logic               overflow;
  logic               discard_err;
  logic               credit_err;
  logic               va_req;
  logic               sa_req;
  logic               latch_vc;
  logic               grant_ok;

  circular_buffer #(
    .BUFFER_SIZE(BUFFER_SIZE)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .data_i    (bus.data_i),
    .write_i   (bus.valid_i),
    .read_i    (buf_pop),
    .data_o    (front),
    .is_full_o (buf_full),
    .is_empty_o(buf_empty),
    .overflow_o(overflow)
  );

  // Grants only count while a request is up; a stray grant does nothing.
  assign grant_ok   = sa_req && bus.sa_grant_i;
  // A returned credit with the counter already full is a protocol error.
  assign credit_err = bus.credit_i && !grant_ok && (credits == CNT_W'(BUFFER_SIZE));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic plus buffer pop, request and error strobes.
  always_comb begin
    state_next  = state;
    buf_pop     = 1'b0;
    discard_err = 1'b0;
    va_req      = 1'b0;
    sa_req      = 1'b0;
    latch_vc    = 1'b0;
    case (state)
      IDLE: begin
        if (!buf_empty) begin
          if (is_head(front.label)) begin
            state_next = VA;
          end else begin
            // Orphan BODY/TAIL with no open packet: drop it and flag it.
            buf_pop     = 1'b1;
            discard_err = 1'b1;
          end
        end
      end
      VA: begin
        va_req = 1'b1;
        if (bus.vc_valid_i) begin
          latch_vc   = 1'b1;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        sa_req = !buf_empty && (credits != '0);
        if (sa_req && bus.sa_grant_i) begin
          buf_pop = 1'b1;
          // Closing the packet here keeps a following HEAD out of this phase.
          if (is_tail(front.label)) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Forwarded flit carries the allocated downstream VC.
  always_comb begin
    fwd       = front;
    fwd.vc_id = vc_q;
  end

  // Downstream credit counter: saturates at BUFFER_SIZE, never underflows
  // because a grant is only honoured with credits above zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      credits <= CNT_W'(BUFFER_SIZE);
    end else begin
      case ({grant_ok, bus.credit_i})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   if (!credit_err) credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // Output register, latched VC and the one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
      credit_q     <= 1'b0;
      error_q      <= 1'b0;
      vc_q         <= '0;
    end else begin
      flit_valid_q <= grant_ok;
      credit_q     <= grant_ok;
      error_q      <= overflow || discard_err || credit_err;
      if (grant_ok) flit_q <= fwd;
      if (latch_vc) vc_q   <= bus.vc_new_i;
    end
  end

  assign bus.va_request_o = va_req;
  assign bus.sa_request_o = sa_req;
  assign bus.flit_o       = flit_q;
  assign bus.flit_valid_o = flit_valid_q;
  assign bus.credit_o     = credit_q;
  assign bus.error_o      = error_q;
  assign bus.is_full_o    = buf_full;
  assign bus.is_empty_o   = buf_empty;
  assign state_o          = state;
  assign credits_o        = credits;

endmodule

// File: tb/tb_vc_buffer_ctrl.sv
// Directed bench for vc_buffer_ctrl: packet forwarding, overflow, credits,
// orphan-flit discard, back-to-back packets and mid-packet reset.
module tb_vc_buffer_ctrl;
  import noc_params::*;

  localparam int BUFFER_SIZE = 8;
  localparam int CW          = $clog2(BUFFER_SIZE) + 1;
  localparam int FW          = $bits(flit_t);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  vc_state_t       state_o;
  logic [CW-1:0]   credits_o;

  logic [FW-1:0]   exp_q[$];
  logic [FW-1:0]   exp_flit;
  int              checks = 0;
  int              errors = 0;
  int              flits_seen = 0;
  int              credit_pulses = 0;
  int              err_pulses = 0;
  int              base_err;
  int              base_flits;
  flit_t           f;

  vc_buffer_ctrl_if bus ();

  vc_buffer_ctrl #(
    .BUFFER_SIZE(BUFFER_SIZE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .state_o  (state_o),
    .credits_o(credits_o)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic flit_t mk(input flit_label_t label, input logic [VC_SIZE-1:0] vc);
    flit_t r;
    r.label = label;
    r.vc_id = vc;
    r.data  = 16'($urandom_range(0, 16'hFFFF));
    return r;
  endfunction

  function automatic logic [FW-1:0] with_vc(input flit_t fl, input logic [VC_SIZE-1:0] vc);
    flit_t r;
    r       = fl;
    r.vc_id = vc;
    return r;
  endfunction

  task automatic write_flit(input flit_t fl);
    bus.data_i  = fl;
    bus.valid_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
  endtask

  // Output monitor: scoreboard pop on every forwarded flit, pulse counters.
  always @(negedge clk) begin
    if (bus.error_o)  err_pulses++;
    if (bus.credit_o) credit_pulses++;
    if (bus.flit_valid_o) begin
      flits_seen++;
      exp_flit = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      check("flit_out", 32'(bus.flit_o), 32'(exp_flit));
    end
  end

  initial begin
    bus.data_i     = '0;
    bus.valid_i    = 1'b0;
    bus.vc_valid_i = 1'b0;
    bus.vc_new_i   = '0;
    bus.sa_grant_i = 1'b0;
    bus.credit_i   = 1'b0;

    // Reset state.
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    check("rst_state",      32'(state_o), 32'(IDLE));
    check("rst_credits",    32'(credits_o), 32'(BUFFER_SIZE));
    check("rst_empty",      32'(bus.is_empty_o), 1);
    check("rst_full",       32'(bus.is_full_o), 0);
    check("rst_va",         32'(bus.va_request_o), 0);
    check("rst_sa",         32'(bus.sa_request_o), 0);
    check("rst_flit_valid", 32'(bus.flit_valid_o), 0);
    check("rst_credit_o",   32'(bus.credit_o), 0);
    check("rst_error",      32'(bus.error_o), 0);
    check("rst_flit",       32'(bus.flit_o), 0);

    // One four-flit packet forwarded on VC 2.
    f = mk(HEAD, 0); exp_q.push_back(with_vc(f, 2)); write_flit(f);
    f = mk(BODY, 0); exp_q.push_back(with_vc(f, 2)); write_flit(f);
    f = mk(BODY, 0); exp_q.push_back(with_vc(f, 2)); write_flit(f);
    f = mk(TAIL, 0); exp_q.push_back(with_vc(f, 2)); write_flit(f);
    check("pkt_state_va", 32'(state_o), 32'(VA));
    check("pkt_va_req",   32'(bus.va_request_o), 1);
    check("pkt_sa_in_va", 32'(bus.sa_request_o), 0);
    bus.vc_valid_i = 1'b1; bus.vc_new_i = 2'd2;
    tick();
    bus.vc_valid_i = 1'b0;
    check("pkt_state_active", 32'(state_o), 32'(ACTIVE));
    check("pkt_sa_req",       32'(bus.sa_request_o), 1);
    check("pkt_va_dropped",   32'(bus.va_request_o), 0);
    bus.sa_grant_i = 1'b1;
    repeat (4) tick();
    bus.sa_grant_i = 1'b0;
    check("pkt_back_idle", 32'(state_o), 32'(IDLE));
    tick();
    check("pkt_flits",      32'(flits_seen), 4);
    check("pkt_credit_o",   32'(credit_pulses), 4);
    check("pkt_q_drained",  32'(exp_q.size()), 0);
    check("pkt_empty",      32'(bus.is_empty_o), 1);
    check("pkt_credits",    32'(credits_o), 4);
    check("pkt_no_error",   32'(err_pulses), 0);
    bus.credit_i = 1'b1;
    repeat (4) tick();
    bus.credit_i = 1'b0;
    check("pkt_credits_back", 32'(credits_o), 8);

    // Overflow: nine writes into eight slots.
    base_err = err_pulses;
    f = mk(HEAD, 0); exp_q.push_back(with_vc(f, 1)); write_flit(f);
    for (int i = 0; i < 7; i++) begin
      f = mk(BODY, 0); exp_q.push_back(with_vc(f, 1)); write_flit(f);
    end
    f = mk(BODY, 0); write_flit(f);
    tick();
    tick();
    check("ovf_full",      32'(bus.is_full_o), 1);
    check("ovf_one_error", 32'(err_pulses - base_err), 1);
    bus.vc_valid_i = 1'b1; bus.vc_new_i = 2'd1;
    tick();
    bus.vc_valid_i = 1'b0;
    check("ovf_sa_req", 32'(bus.sa_request_o), 1);
    // Write and grant together while full.
    f = mk(TAIL, 0); exp_q.push_back(with_vc(f, 1));
    bus.data_i = f; bus.valid_i = 1'b1; bus.sa_grant_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    check("ovf_full_kept", 32'(bus.is_full_o), 1);
    check("ovf_no_error",  32'(err_pulses - base_err), 1);
    repeat (7) tick();
    bus.sa_grant_i = 1'b0;

    // Credits exhausted after eight grants.
    check("cr_zero",       32'(credits_o), 0);
    check("cr_sa_blocked", 32'(bus.sa_request_o), 0);
    check("cr_state",      32'(state_o), 32'(ACTIVE));
    tick();
    base_flits = flits_seen;
    bus.sa_grant_i = 1'b1;
    repeat (2) tick();
    bus.sa_grant_i = 1'b0;
    tick();
    check("cr_grant_ignored", 32'(flits_seen - base_flits), 0);
    check("cr_not_empty",     32'(bus.is_empty_o), 0);
    check("cr_still_zero",    32'(credits_o), 0);
    bus.credit_i = 1'b1;
    tick();
    bus.credit_i = 1'b0;
    check("cr_one",      32'(credits_o), 1);
    check("cr_sa_again", 32'(bus.sa_request_o), 1);
    bus.credit_i = 1'b1; bus.sa_grant_i = 1'b1;
    tick();
    bus.credit_i = 1'b0; bus.sa_grant_i = 1'b0;
    check("cr_both_unchanged", 32'(credits_o), 1);
    check("cr_tail_idle",      32'(state_o), 32'(IDLE));
    tick();
    check("ovf_order_drained", 32'(exp_q.size()), 0);
    check("ovf_empty",         32'(bus.is_empty_o), 1);
    bus.credit_i = 1'b1;
    repeat (7) tick();
    bus.credit_i = 1'b0;
    check("cr_full", 32'(credits_o), 8);
    base_err = err_pulses;
    bus.credit_i = 1'b1;
    tick();
    bus.credit_i = 1'b0;
    tick();
    check("cr_saturate",     32'(credits_o), 8);
    check("cr_satur_error",  32'(err_pulses - base_err), 1);

    // Orphan BODY at the front while idle.
    base_err = err_pulses;
    f = mk(BODY, 0); write_flit(f);
    check("orph_va_0", 32'(bus.va_request_o), 0);
    tick();
    check("orph_popped", 32'(bus.is_empty_o), 1);
    check("orph_va_1",   32'(bus.va_request_o), 0);
    tick();
    check("orph_error", 32'(err_pulses - base_err), 1);
    check("orph_va_2",  32'(bus.va_request_o), 0);
    check("orph_state", 32'(state_o), 32'(IDLE));

    // HEADTAIL followed by a queued HEAD.
    f = mk(HEADTAIL, 0); exp_q.push_back(with_vc(f, 3)); write_flit(f);
    f = mk(HEAD, 0); write_flit(f);
    check("ht_va", 32'(bus.va_request_o), 1);
    bus.vc_valid_i = 1'b1; bus.vc_new_i = 2'd3;
    tick();
    bus.vc_valid_i = 1'b0;
    bus.sa_grant_i = 1'b1;
    tick();
    bus.sa_grant_i = 1'b0;
    check("ht_idle",  32'(state_o), 32'(IDLE));
    check("ht_va_lo", 32'(bus.va_request_o), 0);
    tick();
    check("ht_va_again", 32'(bus.va_request_o), 1);
    check("ht_state_va", 32'(state_o), 32'(VA));

    // Reset in ACTIVE with three flits stored.
    bus.vc_valid_i = 1'b1; bus.vc_new_i = 2'd1;
    tick();
    bus.vc_valid_i = 1'b0;
    f = mk(BODY, 0); write_flit(f);
    f = mk(BODY, 0); write_flit(f);
    check("mr_active", 32'(state_o), 32'(ACTIVE));
    check("mr_loaded", 32'(bus.is_empty_o), 0);
    base_err = err_pulses;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mr_empty",      32'(bus.is_empty_o), 1);
    check("mr_full",       32'(bus.is_full_o), 0);
    check("mr_state",      32'(state_o), 32'(IDLE));
    check("mr_credits",    32'(credits_o), 8);
    check("mr_va",         32'(bus.va_request_o), 0);
    check("mr_sa",         32'(bus.sa_request_o), 0);
    check("mr_flit_valid", 32'(bus.flit_valid_o), 0);
    check("mr_credit_o",   32'(bus.credit_o), 0);
    check("mr_error",      32'(bus.error_o), 0);
    check("mr_flit",       32'(bus.flit_o), 0);
    repeat (2) tick();
    check("mr_no_error_pulse", 32'(err_pulses - base_err), 0);
    check("mr_stays_empty",    32'(bus.is_empty_o), 1);
    check("mr_va_quiet",       32'(bus.va_request_o), 0);
    check("final_q_empty",     32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
